// File: rtl/uart_cmd_sequencer.sv
// ============================================================================
//  Module      : uart_cmd_sequencer
//  Description : Command FIFO and read-response tracker feeding the UART
//                command FSM, with a read-data timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_sequencer #(
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CMD_WIDTH-1:0]     push_cmd,
    input  logic                     push_vld,
    output logic                     push_rdy,
    output logic [CMD_WIDTH-1:0]     cmd_in,
    output logic                     cmd_vld,
    input  logic                     cmd_rdy,
    input  logic                     read_rdy,
    input  logic [READ_WIDTH-1:0]    read_data,
    output logic [READ_WIDTH-1:0]    rsp_data,
    output logic                     rsp_vld,
    output logic                     rsp_err,
    input  logic                     rsp_rdy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_ISSUE    = 2'd1;
    localparam logic [1:0]    c_WAIT_RD  = 2'd2;
    localparam logic [1:0]    c_RSP_HOLD = 2'd3;
    localparam logic [AW:0]   c_FULL     = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

    logic [CMD_WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [TW-1:0]         r_timer;
    logic [READ_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_vld;
    logic                  r_rsp_err;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_is_read;
    logic                  w_timeout;

    assign w_full    = (r_level == c_FULL);
    assign push_rdy  = !w_full && !rst;
    assign cmd_vld   = (r_state == c_ISSUE);
    assign cmd_in    = r_mem[r_rd_ptr];
    assign w_push    = push_vld && push_rdy;
    assign w_pop     = cmd_vld && cmd_rdy;
    assign w_is_read = cmd_in[CMD_WIDTH-1];
    assign w_timeout = (r_timer == c_TMO_LAST);
    assign level     = r_level;
    assign rsp_data  = r_rsp_data;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_err   = r_rsp_err;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_level != '0) begin
                    w_next_state = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (cmd_rdy) begin
                    w_next_state = w_is_read ? c_WAIT_RD : c_IDLE;
                end
            end
            c_WAIT_RD: begin
                if (read_rdy || w_timeout) begin
                    w_next_state = c_RSP_HOLD;
                end
            end
            c_RSP_HOLD: begin
                if (rsp_rdy) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Timer runs only while waiting; read data arriving on the last cycle beats the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer    <= '0;
            r_rsp_data <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_timer <= (r_state == c_WAIT_RD) ? r_timer + TW'(1) : '0;
            if (r_state == c_WAIT_RD) begin
                if (read_rdy) begin
                    r_rsp_data <= read_data;
                    r_rsp_err  <= 1'b0;
                    r_rsp_vld  <= 1'b1;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                    r_rsp_vld  <= 1'b1;
                end
            end else if ((r_state == c_RSP_HOLD) && rsp_rdy) begin
                r_rsp_vld <= 1'b0;
                r_rsp_err <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
